// File: rtl/i2s_tx_pkg.sv
// Shared definitions for the I2S transmitter: FSM state encodings and
// default frame/FIFO geometry. Build option I2S_TX_UNDERRUN_REPEAT_EN
// (see i2s_tx.sv) selects the underrun payload.
package i2s_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_e;

  localparam int DEFAULT_DATA_WIDTH      = 32;
  localparam int DEFAULT_FIFO_ADDR_WIDTH = 4;

endpackage

// File: rtl/i2s_tx_sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data_o always presents the oldest entry,
// rd_en_i acknowledges it. Writes when full and reads when empty are ignored.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH:0]   usedw_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  do_wr, do_rd;

  assign full_o    = (count_q == DEPTH_CNT);
  assign empty_o   = (count_q == '0);
  assign usedw_o   = count_q;
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers and occupancy; simultaneous read and write leave the count unchanged.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter slave: serialises stereo frames from a FIFO onto dacdat,
// slot timing taken from the codec's daclrc. Define I2S_TX_UNDERRUN_REPEAT_EN
// to resend the previous frame on underrun instead of silence.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int FIFO_ADDR_WIDTH = DEFAULT_FIFO_ADDR_WIDTH
) (
  input  logic                     bclk,
  input  logic                     reset,
  input  logic                     daclrc,
  output logic                     dacdat,
  input  logic                     dacfifo_write,
  input  logic [DATA_WIDTH-1:0]    dacfifo_writedata,
  output logic                     dacfifo_full,
  output logic [FIFO_ADDR_WIDTH:0] dacfifo_usedw,
  output logic [15:0]              underrun_cnt
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam int CW   = $clog2(HALF + 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic [HALF-1:0]       shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [15:0]           underrun_q, underrun_d;
  logic                  lrc_r0, lrc_r1;
  logic                  lrc_fall, lrc_rise;
  logic                  pop;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk      (bclk),
    .srst     (reset),
    .wr_en_i  (dacfifo_write),
    .wr_data_i(dacfifo_writedata),
    .rd_en_i  (pop),
    .rd_data_o(fifo_rd_data),
    .usedw_o  (dacfifo_usedw),
    .full_o   (dacfifo_full),
    .empty_o  (fifo_empty)
  );

  // Both sync flops reset low so a daclrc already low after reset gives no edge.
  assign lrc_fall = lrc_r1 && !lrc_r0;
  assign lrc_rise = !lrc_r1 && lrc_r0;

  // Output is the shifter MSB only while bits of the current slot remain.
  assign dacdat       = (state_q != IDLE) && (cnt_q != '0) && shift_q[HALF-1];
  assign underrun_cnt = underrun_q;

  // Slot sequencing: a new frame on falling edge, right half on rising edge.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    underrun_d = underrun_q;
    pop        = 1'b0;
    if (lrc_fall && (state_q != LEFT)) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        frame_d = fifo_rd_data;
      end else begin
        if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        frame_d = frame_q;
`else
        frame_d = '0;
`endif
      end
      shift_d = frame_d[DATA_WIDTH-1:HALF];
      cnt_d   = CW'(HALF);
      state_d = LEFT;
    end else if (lrc_rise && (state_q == LEFT)) begin
      shift_d = frame_q[HALF-1:0];
      cnt_d   = CW'(HALF);
      state_d = RIGHT;
    end else if (cnt_q != '0) begin
      shift_d = shift_q << 1;
      cnt_d   = cnt_q - CW'(1);
    end
  end

  // State, datapath and daclrc synchroniser registers.
  always_ff @(posedge bclk) begin
    if (reset) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      underrun_q <= '0;
      lrc_r0     <= 1'b0;
      lrc_r1     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
      lrc_r0     <= daclrc;
      lrc_r1     <= lrc_r0;
    end
  end

endmodule
